// File: rtl/tlp_tx_arbiter_if.sv
// Bundle of per-source request lanes and the shared PCIe TX Avalon-ST channel.
// The arbiter takes the master view; the environment drives the slave view.
interface tlp_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    logic [NUM_REQ*64-1:0] reqData_in;
    logic [NUM_REQ-1:0]    reqValid_in;
    logic [NUM_REQ-1:0]    reqSOP_in;
    logic [NUM_REQ-1:0]    reqEOP_in;
    logic [NUM_REQ-1:0]    reqReady_out;
    logic [63:0]           txData_out;
    logic                  txValid_out;
    logic                  txSOP_out;
    logic                  txEOP_out;
    logic                  txReady_in;
    logic [NUM_REQ-1:0]    grant_out;
    logic                  errProto_out;
    logic                  errStall_out;

    modport master (
        input  reqData_in, reqValid_in, reqSOP_in, reqEOP_in, txReady_in,
        output reqReady_out, txData_out, txValid_out, txSOP_out, txEOP_out,
        output grant_out, errProto_out, errStall_out
    );

    modport slave (
        output reqData_in, reqValid_in, reqSOP_in, reqEOP_in, txReady_in,
        input  reqReady_out, txData_out, txValid_out, txSOP_out, txEOP_out,
        input  grant_out, errProto_out, errStall_out
    );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 64-bit PCIe TX channel among
// NUM_REQ TLP sources, with a registered output stage and sticky error flags.
module tlp_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic              pcieClk_in,
    input  logic              pcieRstn_in,
    tlp_tx_arbiter_if.master  bus
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e               state_q,     state_d;
    logic [PTR_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]     owner_q,     owner_d;
    logic [NUM_REQ-1:0]   grant_q,     grant_d;
    logic [DATA_W-1:0]    tx_data_q,   tx_data_d;
    logic                 tx_valid_q,  tx_valid_d;
    logic                 tx_sop_q,    tx_sop_d;
    logic                 tx_eop_q,    tx_eop_d;
    logic                 err_proto_q, err_proto_d;
    logic                 err_stall_q, err_stall_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    logic                 slot_free_c;
    logic [NUM_REQ-1:0]   ready_c;
    logic                 win_found_c;
    logic [PTR_W-1:0]     win_idx_c;
    logic                 acc_c;
    logic [PTR_W-1:0]     acc_idx_c;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (32'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // First source offering a SOP beat, searching upward from the round-robin pointer.
    always_comb begin : p_winner
        int unsigned cand;
        cand        = 0;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found_c && bus.reqValid_in[cand] && bus.reqSOP_in[cand]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'(cand);
            end
        end
    end

    // Next-state, handshake and output-register load logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_sop_d    = tx_sop_q;
        tx_eop_d    = tx_eop_q;
        err_proto_d = err_proto_q;
        err_stall_d = err_stall_q;
        stall_cnt_d = stall_cnt_q;
        ready_c     = '0;
        acc_c       = 1'b0;
        acc_idx_c   = '0;

        slot_free_c = ~tx_valid_q | bus.txReady_in;

        if (tx_valid_q && bus.txReady_in) begin
            tx_valid_d = 1'b0;
            tx_sop_d   = 1'b0;
            tx_eop_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                stall_cnt_d = '0;
                // Orphan beats outside a packet are swallowed and flagged.
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (bus.reqValid_in[i] && !bus.reqSOP_in[i]) begin
                        ready_c[i]  = 1'b1;
                        err_proto_d = 1'b1;
                    end
                end
                if (win_found_c) begin
                    ready_c[win_idx_c] = slot_free_c;
                    acc_c              = slot_free_c;
                    acc_idx_c          = win_idx_c;
                end
                if (acc_c) begin
                    if (bus.reqEOP_in[acc_idx_c]) begin
                        rr_ptr_d = next_ptr(acc_idx_c);
                    end else begin
                        state_d = S_BUSY;
                        owner_d = acc_idx_c;
                        grant_d = NUM_REQ'(1) << acc_idx_c;
                    end
                end
            end

            S_BUSY: begin
                ready_c[owner_q] = slot_free_c;
                acc_c            = bus.reqValid_in[owner_q] & slot_free_c;
                acc_idx_c        = owner_q;
                if (acc_c) begin
                    stall_cnt_d = '0;
                    if (bus.reqSOP_in[owner_q]) begin
                        err_proto_d = 1'b1;
                    end
                    if (bus.reqEOP_in[owner_q]) begin
                        state_d  = S_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr(owner_q);
                    end
                end else if (!bus.reqValid_in[owner_q] &&
                             stall_cnt_q < CNT_W'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
                if (stall_cnt_d == CNT_W'(STALL_LIMIT)) begin
                    err_stall_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (acc_c) begin
            tx_data_d  = bus.reqData_in[DATA_W*32'(acc_idx_c) +: DATA_W];
            tx_valid_d = 1'b1;
            tx_sop_d   = bus.reqSOP_in[acc_idx_c];
            tx_eop_d   = bus.reqEOP_in[acc_idx_c];
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstn_in) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            err_proto_q <= 1'b0;
            err_stall_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            err_proto_q <= err_proto_d;
            err_stall_q <= err_stall_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Readiness is held off while reset is asserted so no beat is consumed.
    assign bus.reqReady_out = pcieRstn_in ? ready_c : '0;
    assign bus.txData_out   = tx_data_q;
    assign bus.txValid_out  = tx_valid_q;
    assign bus.txSOP_out    = tx_sop_q;
    assign bus.txEOP_out    = tx_eop_q;
    assign bus.grant_out    = grant_q;
    assign bus.errProto_out = err_proto_q;
    assign bus.errStall_out = err_stall_q;

endmodule
